polyphase_rx_combiner: RTL

// - Downstream of the 8-branch Rx polyphase FIR bank. Sums one output sample from every branch into a single decimated sample.
// - Each FIR branch raises its tvalid independently, so branch outputs may arrive skewed by several cycles.
// - A per-lane FIFO realigns the branches. A pipelined adder tree then produces the full-precision sum.
// - No backpressure exists upstream (FIR tready is unused), so lane overflow is detected and reported, never stalled.

---
 rtl/polyphase_rx_combiner_pkg.sv | 17 +
 rtl/polyphase_rx_combiner_if.sv | 31 +++
 rtl/polyphase_rx_combiner_lane_fifo.sv | 64 ++++++
 rtl/polyphase_rx_combiner.sv | 127 ++++++++++++
 4 files changed

// File: rtl/polyphase_rx_combiner_pkg.sv
// Shared defaults and width helpers for the polyphase Rx combiner slice.
package polyphase_pkg;

  localparam int DEF_N_LANES    = 8;
  localparam int DEF_IN_W       = 32;
  localparam int DEF_FIFO_DEPTH = 4;

  // Each adder level grows the word by one bit, so the sum needs log2(lanes) extra bits.
  function automatic int out_width(input int in_w, input int n_lanes);
    return in_w + $clog2(n_lanes);
  endfunction

  localparam int DEF_OUT_W = out_width(DEF_IN_W, DEF_N_LANES);

  typedef logic signed [DEF_IN_W-1:0] lane_sample_t;

endpackage

// File: rtl/polyphase_rx_combiner_if.sv
// Branch-sample inputs, sum output and sticky status of the combiner, bundled as one port.
interface polyphase_rx_combiner_if
  import polyphase_pkg::*;
#(
  parameter int N_LANES    = DEF_N_LANES,
  parameter int IN_W       = DEF_IN_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);

  localparam int OUT_W = out_width(IN_W, N_LANES);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  logic signed [IN_W-1:0]  polyphase_output [N_LANES-1:0];
  logic [N_LANES-1:0]      polyphase_output_tvalid;
  logic                    clr_err;
  logic signed [OUT_W-1:0] sum_tdata;
  logic                    sum_tvalid;
  logic [N_LANES-1:0]      lane_overflow;
  logic [CW-1:0]           lane_level_max;

  modport master (
    output polyphase_output, polyphase_output_tvalid, clr_err,
    input  sum_tdata, sum_tvalid, lane_overflow, lane_level_max
  );

  modport slave (
    input  polyphase_output, polyphase_output_tvalid, clr_err,
    output sum_tdata, sum_tvalid, lane_overflow, lane_level_max
  );

endinterface

// File: rtl/polyphase_rx_combiner_lane_fifo.sv
// Per-lane first-word-fall-through FIFO; a push into a full FIFO with no pop is dropped and pulses overflow.
module polyphase_lane_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                push,
  input  logic signed [W-1:0] din,
  input  logic                pop,
  output logic signed [W-1:0] dout,
  output logic [CW-1:0]       count,
  output logic                overflow
);

  localparam int PW = $clog2(DEPTH);

  logic signed [W-1:0] mem_q [DEPTH];
  logic signed [W-1:0] mem_d [DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                full, do_push, do_pop;

  // A pop in the same cycle frees a slot, so a full FIFO can still accept a push.
  always_comb begin
    full     = (count_q == CW'(DEPTH));
    do_pop   = pop && (count_q != '0);
    do_push  = push && (!full || do_pop);
    overflow = push && full && !do_pop;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/polyphase_rx_combiner.sv
// Realigns skewed polyphase branch outputs in per-lane FIFOs and sums one sample per lane
// through a registered adder tree, with sticky overflow and occupancy reporting.
module polyphase_rx_combiner
  import polyphase_pkg::*;
#(
  parameter int N_LANES    = DEF_N_LANES,
  parameter int IN_W       = DEF_IN_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rstn,
  polyphase_rx_combiner_if.slave   bus
);

  localparam int LVL   = $clog2(N_LANES);
  localparam int OUT_W = out_width(IN_W, N_LANES);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int HALF  = N_LANES / 2;

  logic signed [IN_W-1:0] head       [N_LANES];
  logic [CW-1:0]          lane_count [N_LANES];
  logic [N_LANES-1:0]     lane_nonempty;
  logic [N_LANES-1:0]     lane_ovf_pulse;
  logic                   all_rdy;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    polyphase_lane_fifo #(
      .W     (IN_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rstn     (rstn),
      .push     (bus.polyphase_output_tvalid[i]),
      .din      (bus.polyphase_output[i]),
      .pop      (all_rdy),
      .dout     (head[i]),
      .count    (lane_count[i]),
      .overflow (lane_ovf_pulse[i])
    );
    assign lane_nonempty[i] = (lane_count[i] != '0);
  end

  // Registered counts only: a sample pushed this cycle cannot complete a set until next cycle.
  assign all_rdy = &lane_nonempty;

  logic signed [OUT_W-1:0] operand [LVL][N_LANES];
  logic signed [OUT_W-1:0] tree_q  [LVL][HALF];
  logic signed [OUT_W-1:0] tree_d  [LVL][HALF];
  logic [LVL-1:0]          vld_q, vld_d;

  // Working at full output width equals per-level sign extension, as no level can overflow.
  always_comb begin
    for (int k = 0; k < LVL; k++) begin
      for (int i = 0; i < N_LANES; i++) begin
        operand[k][i] = '0;
      end
    end
    for (int i = 0; i < N_LANES; i++) begin
      operand[0][i] = OUT_W'(head[i]);
    end
    for (int k = 1; k < LVL; k++) begin
      for (int i = 0; i < (N_LANES >> k); i++) begin
        operand[k][i] = tree_q[k-1][i];
      end
    end

    vld_d[0] = all_rdy;
    for (int k = 1; k < LVL; k++) begin
      vld_d[k] = vld_q[k-1];
    end

    tree_d = tree_q;
    for (int k = 0; k < LVL; k++) begin
      for (int j = 0; j < (N_LANES >> (k + 1)); j++) begin
        if (vld_d[k]) begin
          tree_d[k][j] = operand[k][2*j] + operand[k][2*j+1];
        end
      end
    end
  end

  logic [N_LANES-1:0] ovf_q, ovf_d;
  logic [CW-1:0]      lvl_max_q, lvl_max_d;
  logic [CW-1:0]      occ_max;

  // A fresh overflow pulse is ORed in after the clear so it survives a simultaneous clr_err.
  always_comb begin
    occ_max = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (lane_count[i] > occ_max) begin
        occ_max = lane_count[i];
      end
    end
    ovf_d = (bus.clr_err ? '0 : ovf_q) | lane_ovf_pulse;
    if (bus.clr_err) begin
      lvl_max_d = '0;
    end else if (occ_max > lvl_max_q) begin
      lvl_max_d = occ_max;
    end else begin
      lvl_max_d = lvl_max_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < LVL; k++) begin
        for (int j = 0; j < HALF; j++) begin
          tree_q[k][j] <= '0;
        end
      end
      vld_q     <= '0;
      ovf_q     <= '0;
      lvl_max_q <= '0;
    end else begin
      tree_q    <= tree_d;
      vld_q     <= vld_d;
      ovf_q     <= ovf_d;
      lvl_max_q <= lvl_max_d;
    end
  end

  assign bus.sum_tdata      = tree_q[LVL-1][0];
  assign bus.sum_tvalid     = vld_q[LVL-1];
  assign bus.lane_overflow  = ovf_q;
  assign bus.lane_level_max = lvl_max_q;

endmodule
